// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch stage and its IF/ID slot:
//   - fetch FSM state encodings (RUN, DRAIN, HALT) as localparam constants
//   - HALT opcode and the default reset PC
//   - packed slot payload {instr, pc, pc_plus2, err}
//   - is_stop(): true when a fetched word must stop the fetch stream
package fetch_pkg;

   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
   localparam logic [4:0]  HALT_OPC         = 5'b00000;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_RUN   = 2'd0;
   localparam fetch_state_t ST_DRAIN = 2'd1;
   localparam fetch_state_t ST_HALT  = 2'd2;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] pc_plus2;
      logic        err;
   } slot_t;

   // A HALT opcode or a fetch fault both end the fetch stream.
   function automatic logic is_stop(input logic [15:0] instr, input logic err);
      return (instr[15:11] == HALT_OPC) || err;
   endfunction

endpackage

// File: rtl/fetch_unit_slot.sv
// if_id_slot
// Single-entry valid/ready register between fetch and decode.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load_i      : capture data_i (only issued when the slot is empty or
//                 being emptied this cycle)
//   flush_i     : drop the current entry; wins over load_i
//   hold_i      : consumer is not taking the entry this cycle
//   data_i      : payload to capture
//   valid_o     : slot holds an entry
//   data_o      : current payload, stable while valid_o=1 and hold_i=1
module if_id_slot
   import fetch_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load_i,
   input  logic  flush_i,
   input  logic  hold_i,
   input  slot_t data_i,
   output logic  valid_o,
   output slot_t data_o
);

   logic  valid_d, valid_q;
   slot_t data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (!hold_i) begin
         // Entry (if any) was accepted by decode this cycle.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// request outstanding, and hands fetched words to decode through if_id_slot.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   imem_req/imem_addr              : fetch request, held with a stable
//                                     address until imem_ack
//   imem_ack/imem_data/imem_err     : response (may be same-cycle)
//   redirect_valid/redirect_pc      : resolved taken branch / jump target
//   id_valid/id_ready               : output slot handshake to decode
//   id_instr/id_pc/id_pc_plus2/id_err : slot payload
//   halted                          : fetch stopped by HALT or fault
//   state_dbg                       : current FSM state (RUN/DRAIN/HALT)
//
// Handshakes: a slot transfer happens in any cycle with id_valid=1 and
// id_ready=1; the payload is stable while id_valid=1 and id_ready=0.
// A memory transfer happens in any cycle with imem_req=1 and imem_ack=1;
// imem_req and imem_addr do not change between issue and that cycle.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   input  logic        imem_err,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [15:0] id_instr,
   output logic [15:0] id_pc,
   output logic [15:0] id_pc_plus2,
   output logic        id_err,
   output logic        halted,
   output logic [1:0]  state_dbg
);

   fetch_state_t state_d, state_q;
   logic [15:0]  pc_d, pc_q;
   logic [15:0]  req_addr_d, req_addr_q;
   logic         pend_d, pend_q;

   logic  issue;
   logic  ack;
   logic  still_waiting;
   logic  slot_load;
   logic  slot_flush;
   logic  slot_valid;
   slot_t slot_in;
   slot_t slot_out;

   // Request side. A new request only starts when the slot will have room
   // for its answer, so a returning ack never finds the slot occupied.
   always_comb begin
      issue         = (state_q == ST_RUN) && !pend_q && (!slot_valid || id_ready);
      imem_req      = rst_n && (pend_q || issue);
      imem_addr     = pend_q ? req_addr_q : pc_q;
      ack           = imem_req && imem_ack;
      still_waiting = imem_req && !imem_ack;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = still_waiting;
      req_addr_d = imem_addr;
      slot_load  = 1'b0;
      slot_flush = 1'b0;
      slot_in    = '{instr: imem_data, pc: pc_q, pc_plus2: pc_q + 16'd2, err: imem_err};

      if (redirect_valid) begin
         // Redirect beats ack capture and halt detection. A request still in
         // flight must be completed and its answer thrown away (DRAIN).
         slot_flush = 1'b1;
         pc_d       = redirect_pc;
         state_d    = still_waiting ? ST_DRAIN : ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (ack) begin
                  slot_load = 1'b1;
                  pc_d      = pc_q + 16'd2;
                  if (is_stop(imem_data, imem_err)) begin
                     state_d = ST_HALT;
                  end
               end
            end
            ST_DRAIN: begin
               if (ack) begin
                  state_d = ST_RUN;
               end
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         pend_q     <= pend_d;
      end
   end

   if_id_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (slot_load),
      .flush_i (slot_flush),
      .hold_i  (!id_ready),
      .data_i  (slot_in),
      .valid_o (slot_valid),
      .data_o  (slot_out)
   );

   assign id_valid    = slot_valid;
   assign id_instr    = slot_out.instr;
   assign id_pc       = slot_out.pc;
   assign id_pc_plus2 = slot_out.pc_plus2;
   assign id_err      = slot_out.err;
   assign halted      = (state_q == ST_HALT);
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Bench for fetch_unit: a memory model with configurable latency answers the
// requests, and a stream-level reference (next expected PC, memory image)
// checks every instruction decode accepts.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [15:0] RESET_PC = DEFAULT_RESET_PC;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic        imem_req, imem_ack, imem_err;
   logic [15:0] imem_addr, imem_data;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        id_valid, id_ready, id_err, halted;
   logic [15:0] id_instr, id_pc, id_pc_plus2;
   logic [1:0]  state_dbg;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_data      (imem_data),
      .imem_err       (imem_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus2    (id_pc_plus2),
      .id_err         (id_err),
      .halted         (halted),
      .state_dbg      (state_dbg)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   int unsigned lat = 0;
   int unsigned wait_cnt = 0;
   logic        halt_en = 1'b0, err_en = 1'b0, halt_pat = 1'b0, err_pat = 1'b0;
   logic [15:0] halt_addr = 16'h0, err_addr = 16'h0;

   function automatic logic mem_halt(input logic [15:0] a);
      return (halt_en && a == halt_addr) || (halt_pat && a[6:1] == 6'd42);
   endfunction

   function automatic logic mem_err(input logic [15:0] a);
      return (err_en && a == err_addr) || (err_pat && a[6:1] == 6'd21);
   endfunction

   // Ordinary words are ADDI-range (0x4000..0x47FF); HALT words are 0x0000.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return mem_halt(a) ? 16'h0000 : {5'b01000, a[11:1]};
   endfunction

   always_comb begin
      imem_ack  = imem_req && (wait_cnt >= lat);
      imem_data = mem_word(imem_addr);
      imem_err  = mem_err(imem_addr);
   end

   always @(posedge clk) begin
      if (!rst_n || !imem_req || imem_ack) wait_cnt <= 0;
      else                                 wait_cnt <= wait_cnt + 1;
   end

   // ---------------- scoreboard / protocol monitor ----------------
   logic [15:0] exp_pc = RESET_PC;
   logic [15:0] exp_p2;
   logic [15:0] exp_word;
   logic        prev_pend = 1'b0, prev_hold = 1'b0, prev_err = 1'b0;
   logic [15:0] prev_addr = 16'h0, prev_pc = 16'h0, prev_instr = 16'h0;
   int          n_deliv = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_pc    = RESET_PC;
         prev_pend = 1'b0;
         prev_hold = 1'b0;
      end else begin
         if (prev_pend) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", 32'(imem_addr), 32'(prev_addr));
         end
         if (halted) chk("halt_no_req", 32'(imem_req), 32'd0);
         if (prev_hold) begin
            chk("slot_held_v", 32'(id_valid), 32'd1);
            chk("slot_held_pc", 32'(id_pc), 32'(prev_pc));
            chk("slot_held_instr", 32'(id_instr), 32'(prev_instr));
            chk("slot_held_err", 32'(id_err), 32'(prev_err));
         end
         if (id_valid && id_ready && !redirect_valid) begin
            exp_p2   = exp_pc + 16'd2;
            exp_word = mem_word(exp_pc);
            chk("id_pc", 32'(id_pc), 32'(exp_pc));
            chk("id_instr", 32'(id_instr), 32'(exp_word));
            chk("id_pc_plus2", 32'(id_pc_plus2), 32'(exp_p2));
            chk("id_err", 32'(id_err), 32'(mem_err(exp_pc)));
            chk("id_halted", 32'(halted), 32'(mem_halt(exp_pc) || mem_err(exp_pc)));
            exp_pc = exp_p2;
            n_deliv++;
         end
         if (redirect_valid) exp_pc = redirect_pc;
         prev_pend  = imem_req && !imem_ack;
         prev_addr  = imem_addr;
         prev_hold  = id_valid && !id_ready && !redirect_valid;
         prev_pc    = id_pc;
         prev_instr = id_instr;
         prev_err   = id_err;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      redirect_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pulse_redirect(input logic [15:0] target);
      @(posedge clk);
      #1 redirect_valid = 1'b1;
      redirect_pc = target;
   endtask

   task automatic end_redirect();
      @(posedge clk);
      #1 redirect_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic got;
   int   ack_cyc;
   int   base;

   initial begin
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0;

      // Reset values.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_instr", 32'(id_instr), 32'd0);
      chk("rst_pc", 32'(id_pc), 32'd0);
      chk("rst_pc2", 32'(id_pc_plus2), 32'd0);
      chk("rst_err", 32'(id_err), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);

      // Combinational memory, decode always ready: one fetch per cycle.
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("seq_req", 32'(imem_req), 32'd1);
         chk("seq_addr", 32'(imem_addr), 32'(2 * (k - 1)));
         chk("seq_valid", 32'(id_valid), 32'(k >= 2));
         if (k >= 2) begin
            chk("seq_pc", 32'(id_pc), 32'(2 * (k - 2)));
            chk("seq_pc2", 32'(id_pc_plus2), 32'(2 * (k - 1)));
         end
      end

      // Latency 3, decode stalls for 5 cycles after the first ack.
      lat = 3;
      do_reset();
      got = 1'b0;
      ack_cyc = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (imem_ack) begin
            got = 1'b1;
            ack_cyc = i;
         end
      end
      chk("lat3_ack_seen", 32'(got), 32'd1);
      chk("lat3_ack_cycle", 32'(ack_cyc), 32'd4);
      chk("lat3_first_addr", 32'(imem_addr), 32'd0);
      #1 id_ready = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_no_req", 32'(imem_req), 32'd0);
         chk("stall_valid", 32'(id_valid), 32'd1);
         chk("stall_pc", 32'(id_pc), 32'd0);
      end
      @(posedge clk);
      #1 id_ready = 1'b1;
      @(negedge clk);
      chk("unstall_req", 32'(imem_req), 32'd1);
      chk("unstall_addr", 32'(imem_addr), 32'd2);

      // Redirect while the latency-3 request to 0x0004 is in flight.
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 16'h0004) got = 1'b1;
      end
      chk("pend4_seen", 32'(got), 32'd1);
      pulse_redirect(16'h0100);
      @(negedge clk);
      chk("drain_req", 32'(imem_req), 32'd1);
      chk("drain_addr0", 32'(imem_addr), 32'h4);
      end_redirect();
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         chk("drain_addr", 32'(imem_addr), 32'h4);
         if (imem_ack) got = 1'b1;
      end
      chk("drain_ack_seen", 32'(got), 32'd1);
      @(negedge clk);
      chk("post_drain_req", 32'(imem_req), 32'd1);
      chk("post_drain_addr", 32'(imem_addr), 32'h100);
      chk("post_drain_valid", 32'(id_valid), 32'd0);

      // HALT word at 0x0006, then resume by redirect.
      lat = 0;
      halt_en = 1'b1;
      halt_addr = 16'h0006;
      do_reset();
      base = n_deliv;
      repeat (10) @(negedge clk);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_count", 32'(n_deliv - base), 32'd4);
      chk("halt_drained", 32'(id_valid), 32'd0);
      pulse_redirect(16'h0020);
      @(negedge clk);
      chk("halt_redir_req", 32'(imem_req), 32'd0);
      end_redirect();
      @(negedge clk);
      chk("resume_halted", 32'(halted), 32'd0);
      chk("resume_req", 32'(imem_req), 32'd1);
      chk("resume_addr", 32'(imem_addr), 32'h20);

      // Fetch fault at 0x0010.
      halt_en = 1'b0;
      err_en = 1'b1;
      err_addr = 16'h0010;
      lat = 1;
      do_reset();
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (id_valid && id_pc == 16'h0010) got = 1'b1;
      end
      chk("err_seen", 32'(got), 32'd1);
      chk("err_flag", 32'(id_err), 32'd1);
      chk("err_halted", 32'(halted), 32'd1);
      repeat (3) @(negedge clk);
      chk("err_no_req", 32'(imem_req), 32'd0);

      // PC wrap at 0xFFFE.
      err_en = 1'b0;
      lat = 0;
      do_reset();
      pulse_redirect(16'hFFFC);
      end_redirect();
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (id_valid && id_pc == 16'hFFFE) got = 1'b1;
      end
      chk("wrap_seen", 32'(got), 32'd1);
      chk("wrap_pc2", 32'(id_pc_plus2), 32'd0);
      chk("wrap_req", 32'(imem_req), 32'd1);
      chk("wrap_addr", 32'(imem_addr), 32'd0);

      // Redirect in the same cycle as a combinational ack.
      pulse_redirect(16'h0200);
      @(negedge clk);
      chk("same_cyc_ack", 32'(imem_ack), 32'd1);
      end_redirect();
      @(negedge clk);
      chk("same_cyc_req", 32'(imem_req), 32'd1);
      chk("same_cyc_addr", 32'(imem_addr), 32'h200);
      chk("same_cyc_valid", 32'(id_valid), 32'd0);
      @(negedge clk);
      chk("same_cyc_next_v", 32'(id_valid), 32'd1);
      chk("same_cyc_next_pc", 32'(id_pc), 32'h200);

      // Random traffic: ready, latency, redirects, HALT/fault words.
      halt_pat = 1'b1;
      err_pat = 1'b1;
      lat = $urandom_range(0, 3);
      do_reset();
      base = n_deliv;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         id_ready = ($urandom_range(0, 3) != 0);
         if (c % 150 == 0) lat = $urandom_range(0, 3);
         if (redirect_valid) begin
            redirect_valid = 1'b0;
         end else if ($urandom_range(0, 24) == 0 || (halted && $urandom_range(0, 3) == 0)) begin
            redirect_valid = 1'b1;
            redirect_pc = 16'($urandom) & 16'hFFFE;
         end
      end
      #1 redirect_valid = 1'b0;
      @(negedge clk);
      chk("rand_progress", 32'((n_deliv - base) > 200), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Time limit for the whole run.
   initial begin
      #2000000;
      n_errors++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
